// File: rtl/uwb_tx_pkg.sv
// Shared types and defaults for the UWB serial transmitter.
// The auxiliary channel is present only when AUX_CHANNEL_EN is defined.
package uwb_tx_pkg;

    typedef enum logic [1:0] {IDLE, TX, DONE} state_t;

    localparam int DEF_DATA_W        = 128;
    localparam int DEF_SYMBOL_CYCLES = 8;
    localparam int DEF_PW_W          = 2;

    // A width code n means n+1 cycles, never longer than half a symbol.
    function automatic int clamp_width(input int code, input int sym_cycles);
        int w;
        w = code + 1;
        if (w > sym_cycles / 2)
            w = sym_cycles / 2;
        return w;
    endfunction

endpackage

// File: rtl/uwb_serial_transmitter_pulse_gen.sv
// Symbol counter, width latch and registered PPM pulse shaping.
// AUX_CHANNEL_EN selects whether the aux bit chooses pw1 or pw2.
module uwb_pulse_gen
    import uwb_tx_pkg::*;
#(
    parameter int SYMBOL_CYCLES = DEF_SYMBOL_CYCLES,
    parameter int PW_W          = DEF_PW_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sym_en,
    input  logic            data_bit,
    input  logic            aux_bit,
    input  logic [PW_W-1:0] pw1_bb0,
    input  logic [PW_W-1:0] pw2_bb0,
    input  logic [PW_W-1:0] pw1_bb1,
    input  logic [PW_W-1:0] pw2_bb1,
    output logic            pulse,
    output logic            symbol_end
);

    localparam int CW   = $clog2(SYMBOL_CYCLES);
    localparam int CW1  = CW + 1;
    localparam int HALF = SYMBOL_CYCLES / 2;

    logic            active;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [CW-1:0]   width_q;
    logic [CW-1:0]   width_new;
    logic [CW-1:0]   width_use;
    logic [CW1-1:0]  start;
    logic [PW_W-1:0] code;
    logic            pulse_nxt;

`ifndef AUX_CHANNEL_EN
    logic unused_aux;
    assign unused_aux = ^{aux_bit, pw2_bb0, pw2_bb1};
`endif

    assign symbol_end = active && (cnt == CW'(SYMBOL_CYCLES - 1));

    // Values for the next cycle; inputs describe that cycle's bit pair.
    always_comb begin
`ifdef AUX_CHANNEL_EN
        unique case ({data_bit, aux_bit})
            2'b00:   code = pw1_bb0;
            2'b01:   code = pw2_bb0;
            2'b10:   code = pw1_bb1;
            default: code = pw2_bb1;
        endcase
`else
        code = data_bit ? pw1_bb1 : pw1_bb0;
`endif
        cnt_nxt   = (active && !symbol_end) ? cnt + 1'b1 : '0;
        width_new = CW'(clamp_width(int'(code), SYMBOL_CYCLES));
        width_use = (cnt_nxt == '0) ? width_new : width_q;
        start     = data_bit ? CW1'(HALF) : '0;
        pulse_nxt = sym_en
                 && ({1'b0, cnt_nxt} >= start)
                 && ({1'b0, cnt_nxt} < start + {1'b0, width_use});
    end

    // Advance the counter, latch width at symbol start, register the pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            cnt     <= '0;
            width_q <= '0;
            pulse   <= 1'b0;
        end else begin
            active <= sym_en;
            cnt    <= sym_en ? cnt_nxt : '0;
            if (sym_en && cnt_nxt == '0)
                width_q <= width_new;
            pulse <= pulse_nxt;
        end
    end

endmodule

// File: rtl/uwb_serial_transmitter.sv
// Frame FSM and MSB-first shift registers feeding the PPM pulse generator.
// Define AUX_CHANNEL_EN to capture sk and use it for width selection.
module uwb_serial_transmitter
    import uwb_tx_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int SYMBOL_CYCLES = DEF_SYMBOL_CYCLES,
    parameter int PW_W          = DEF_PW_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send,
    input  logic [DATA_W-1:0] content,
    input  logic [DATA_W-1:0] sk,
    input  logic [PW_W-1:0]   pw1_bb0,
    input  logic [PW_W-1:0]   pw2_bb0,
    input  logic [PW_W-1:0]   pw1_bb1,
    input  logic [PW_W-1:0]   pw2_bb1,
    output logic              uwb_out,
    output logic              busy,
    output logic              done
);

    localparam int BW = $clog2(DATA_W);

    state_t            state;
    logic [DATA_W-1:0] data_sr;
    logic [BW-1:0]     bit_cnt;
    logic              symbol_end;
    logic              last_bit;
    logic              tx_nxt;
    logic              bit_nxt;
    logic              aux_nxt;

`ifdef AUX_CHANNEL_EN
    logic [DATA_W-1:0] aux_sr;
`else
    logic unused_sk;
    assign unused_sk = ^sk;
`endif

    assign last_bit = (bit_cnt == BW'(DATA_W - 1));

    // Look one cycle ahead so the pulse register lines up with the symbol.
    always_comb begin
        tx_nxt  = 1'b0;
        bit_nxt = data_sr[DATA_W-1];
        aux_nxt = 1'b0;
`ifdef AUX_CHANNEL_EN
        aux_nxt = aux_sr[DATA_W-1];
`endif
        unique case (state)
            IDLE: begin
                tx_nxt  = send;
                bit_nxt = content[DATA_W-1];
`ifdef AUX_CHANNEL_EN
                aux_nxt = sk[DATA_W-1];
`endif
            end
            TX: begin
                tx_nxt = !(symbol_end && last_bit);
                if (symbol_end) begin
                    bit_nxt = data_sr[DATA_W-2];
`ifdef AUX_CHANNEL_EN
                    aux_nxt = aux_sr[DATA_W-2];
`endif
                end
            end
            default: ;
        endcase
    end

    // Frame sequencing, capture and shifting with registered busy/done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            data_sr <= '0;
`ifdef AUX_CHANNEL_EN
            aux_sr  <= '0;
`endif
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (send) begin
                        data_sr <= content;
`ifdef AUX_CHANNEL_EN
                        aux_sr  <= sk;
`endif
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= TX;
                    end
                end
                TX: begin
                    if (symbol_end) begin
                        data_sr <= {data_sr[DATA_W-2:0], 1'b0};
`ifdef AUX_CHANNEL_EN
                        aux_sr  <= {aux_sr[DATA_W-2:0], 1'b0};
`endif
                        bit_cnt <= bit_cnt + 1'b1;
                        if (last_bit) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    uwb_pulse_gen #(
        .SYMBOL_CYCLES(SYMBOL_CYCLES),
        .PW_W         (PW_W)
    ) u_pulse (
        .clk       (clk),
        .rst       (rst),
        .sym_en    (tx_nxt),
        .data_bit  (bit_nxt),
        .aux_bit   (aux_nxt),
        .pw1_bb0   (pw1_bb0),
        .pw2_bb0   (pw2_bb0),
        .pw1_bb1   (pw1_bb1),
        .pw2_bb1   (pw2_bb1),
        .pulse     (uwb_out),
        .symbol_end(symbol_end)
    );

endmodule

// File: tb/tb_uwb_serial_transmitter.sv
// Bench for uwb_serial_transmitter: default instance plus a small
// 8-bit / 4-cycle instance for the width clamp boundary.
module tb_uwb_serial_transmitter;

    localparam int DW = 128;
    localparam int SC = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          send;
    logic [DW-1:0] content, sk;
    logic [1:0]    pw1_bb0, pw2_bb0, pw1_bb1, pw2_bb1;
    logic          uwb_out, busy, done;

    logic          send_s;
    logic [7:0]    content_s, sk_s;
    logic [1:0]    p1b0_s, p2b0_s, p1b1_s, p2b1_s;
    logic          uwb_s, busy_s, done_s;

    int checks   = 0;
    int failures = 0;

    logic [SC-1:0] obs [DW];

    uwb_serial_transmitter u_dut (
        .clk(clk), .rst(rst), .send(send),
        .content(content), .sk(sk),
        .pw1_bb0(pw1_bb0), .pw2_bb0(pw2_bb0),
        .pw1_bb1(pw1_bb1), .pw2_bb1(pw2_bb1),
        .uwb_out(uwb_out), .busy(busy), .done(done)
    );

    uwb_serial_transmitter #(
        .DATA_W(8), .SYMBOL_CYCLES(4), .PW_W(2)
    ) u_small (
        .clk(clk), .rst(rst), .send(send_s),
        .content(content_s), .sk(sk_s),
        .pw1_bb0(p1b0_s), .pw2_bb0(p2b0_s),
        .pw1_bb1(p1b1_s), .pw2_bb1(p2b1_s),
        .uwb_out(uwb_s), .busy(busy_s), .done(done_s)
    );

    typedef struct {
        logic [7:0]  c;
        logic [1:0]  p0;
        logic [1:0]  p1;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_width(input int code, input int sc);
        return (code + 1 > sc / 2) ? sc / 2 : code + 1;
    endfunction

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full frame on the default instance against the reference model.
    task automatic run_frame(input logic [DW-1:0] c, input logic [DW-1:0] s,
                             input logic [1:0] a0, input logic [1:0] b0,
                             input logic [1:0] a1, input logic [1:0] b1,
                             input int resend_at, input bit jitter,
                             input bit hold, input string name);
        logic [DW-1:0] cap_c;
        logic [DW-1:0] cap_s;
        int errs, berrs, first;
        int w, st, b, a, code, cyc, i;
        logic exp_bit;
        cap_c = c;
        cap_s = s;
        errs = 0;
        berrs = 0;
        first = -1;
        w = 0;
        st = 0;
        content = c; sk = s;
        pw1_bb0 = a0; pw2_bb0 = b0; pw1_bb1 = a1; pw2_bb1 = b1;
        send = 1'b1;
        tick;
        if (!hold) send = 1'b0;
        content = ~c;
        sk = ~s;
        for (int k = 0; k < DW * SC; k++) begin
            cyc = k % SC;
            i = k / SC;
            if (cyc == 0) begin
                b = int'(cap_c[DW-1-i]);
`ifdef AUX_CHANNEL_EN
                a = int'(cap_s[DW-1-i]);
`else
                a = 0;
`endif
                if (b == 1) code = (a == 1) ? int'(pw2_bb1) : int'(pw1_bb1);
                else        code = (a == 1) ? int'(pw2_bb0) : int'(pw1_bb0);
                w = ref_width(code, SC);
                st = (b == 1) ? SC / 2 : 0;
            end
            exp_bit = (cyc >= st) && (cyc < st + w);
            obs[i][SC-1-cyc] = uwb_out;
            if (uwb_out !== exp_bit) begin
                errs++;
                if (first < 0) first = k;
            end
            if (busy !== 1'b1 || done !== 1'b0) berrs++;
            if (k == resend_at) send = 1'b1;
            else if (!hold) send = 1'b0;
            if (jitter && cyc == 3) begin
                pw1_bb0 = 2'($urandom); pw2_bb0 = 2'($urandom);
                pw1_bb1 = 2'($urandom); pw2_bb1 = 2'($urandom);
            end
            tick;
        end
        if (errs != 0)
            $display("first bad pulse cycle in %s: %0d", name, first);
        check({name, " pulse_errs"}, errs, 0);
        check({name, " busy_errs"}, berrs, 0);
        check({name, " done"}, {busy, done, uwb_out}, 3'b010);
        tick;
        check({name, " idle"}, {busy, done, uwb_out}, 3'b000);
    endtask

    initial begin
        int n;
        logic [31:0] got;
        logic [DW-1:0] c;

        tbl[0] = '{8'hFF, 2'd0, 2'd3, 32'h3333_3333};
        tbl[1] = '{8'h00, 2'd3, 2'd0, 32'hCCCC_CCCC};
        tbl[2] = '{8'hA5, 2'd1, 2'd0, 32'h2C2C_C2C2};
        tbl[3] = '{8'h0F, 2'd0, 2'd1, 32'h8888_3333};

        rst = 1'b1;
        send = 1'b0; content = '0; sk = '0;
        pw1_bb0 = '0; pw2_bb0 = '0; pw1_bb1 = '0; pw2_bb1 = '0;
        send_s = 1'b0; content_s = '0; sk_s = '0;
        p1b0_s = '0; p2b0_s = 2'd3; p1b1_s = '0; p2b1_s = 2'd1;
        repeat (2) tick;
        check("reset outputs", {uwb_out, busy, done}, 3'b000);
        check("reset small", {uwb_s, busy_s, done_s}, 3'b000);
        rst = 1'b0;
        tick;

        for (int t = 0; t < 4; t++) begin
            content_s = tbl[t].c;
            p1b0_s = tbl[t].p0;
            p1b1_s = tbl[t].p1;
            send_s = 1'b1;
            tick;
            send_s = 1'b0;
            got = '0;
            for (int k = 0; k < 32; k++) begin
                got[31-k] = uwb_s;
                tick;
            end
            check($sformatf("small vec%0d pulses", t), got, tbl[t].exp);
            check($sformatf("small vec%0d done", t),
                  {busy_s, done_s}, 2'b01);
            tick;
        end

        run_frame('0, '0, 2'd0, 2'd0, 2'd0, 2'd0, -1, 0, 0, "all_zero");
        n = 0;
        for (int i = 0; i < DW; i++) if (obs[i] == 8'h80) n++;
        check("all_zero slot0 pulses", n, DW);

        c = {16{8'hAA}};
        run_frame(c, '0, 2'd0, 2'd0, 2'd0, 2'd0, -1, 0, 0, "ppm_aa");
        check("ppm_aa sym0", obs[0], 8'h08);
        check("ppm_aa sym1", obs[1], 8'h80);

        run_frame(128'hAAAAAAAA, 128'h0000FFFF, 2'd0, 2'd2, 2'd0, 2'd2,
                  -1, 0, 0, "aux");
        n = 0;
        for (int i = 0; i < DW; i++) if ($countones(obs[i]) == 3) n++;
`ifdef AUX_CHANNEL_EN
        check("aux wide symbols", n, 16);
`else
        check("aux wide symbols", n, 0);
`endif

        run_frame(rnd128(), rnd128(), 2'd1, 2'd2, 2'd3, 2'd0,
                  100, 0, 0, "resend");

        run_frame(rnd128(), rnd128(), 2'd2, 2'd0, 2'd1, 2'd3,
                  -1, 0, 1, "hold_a");
        run_frame(rnd128(), rnd128(), 2'd0, 2'd3, 2'd2, 2'd1,
                  -1, 0, 0, "hold_b");

        for (int r = 0; r < 3; r++)
            run_frame(rnd128(), rnd128(),
                      2'($urandom), 2'($urandom),
                      2'($urandom), 2'($urandom),
                      -1, 1, 0, $sformatf("rand%0d", r));

        content = '1; sk = '0;
        pw1_bb0 = 2'd0; pw1_bb1 = 2'd3; pw2_bb0 = 2'd0; pw2_bb1 = 2'd3;
        send = 1'b1;
        tick;
        send = 1'b0;
        repeat (40 * SC + 5) tick;
        check("pre-reset pulse", {uwb_out, busy}, 2'b11);
        rst = 1'b1;
        #1;
        check("mid-frame reset", {uwb_out, busy, done}, 3'b000);
        n = 0;
        repeat (2) begin
            tick;
            if (done !== 1'b0) n++;
        end
        rst = 1'b0;
        tick;
        if (done !== 1'b0) n++;
        check("no done after abort", n, 0);
        run_frame(rnd128(), rnd128(), 2'd1, 2'd1, 2'd2, 2'd2,
                  -1, 0, 0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uwb_serial_transmitter.md
Name: uwb_serial_transmitter

Overview:
- Loads a 128-bit data word and a 128-bit auxiliary word on `send`.
- Serializes both words in lockstep, MSB first, one bit pair per symbol.
- Emits a pulse-position-modulated UWB pulse train on `uwb_out`. The data bit picks the pulse position; the auxiliary bit picks which of two configured pulse widths is used.
- Sits between the payload/key source and the RF front-end driver.

Parameters:
- DATA_W, 128, width of the content and auxiliary words (bits per frame).
- SYMBOL_CYCLES, 8, clock cycles per symbol; must be even and ≥ 4.
- PW_W, 2, width of each pulse-width configuration input.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- send  in  1  start request; sampled only while idle.
- content  in  DATA_W  data word; captured on accepted send.
- sk  in  DATA_W  auxiliary word; captured on accepted send.
- pw1_bb0  in  PW_W  width code, data bit 0, aux bit 0.
- pw2_bb0  in  PW_W  width code, data bit 0, aux bit 1.
- pw1_bb1  in  PW_W  width code, data bit 1, aux bit 0.
- pw2_bb1  in  PW_W  width code, data bit 1, aux bit 1.
- uwb_out  out  1  pulse output.
- busy  out  1  frame in progress.
- done  out  1  one-cycle strobe at frame end.

Behaviour:
- Reset (async, active-high): state IDLE, shift registers cleared, counters cleared, uwb_out=0, busy=0, done=0.
- FSM has three states: IDLE, TX, DONE.
- IDLE:
  - send=1 at an edge captures content and sk into shift registers, sets busy=1 and moves to TX.
  - The first symbol starts on the next cycle (1-cycle latency).
- TX:
  - Current bits are shift-register MSBs: b (data) and a (aux).
  - Symbol counter runs 0..SYMBOL_CYCLES-1.
  - At counter 0, latch the width code: {b,a} = 00 → pw1_bb0, 01 → pw2_bb0, 10 → pw1_bb1, 11 → pw2_bb1.
  - Pulse width W = code+1 cycles, clamped to SYMBOL_CYCLES/2.
  - Pulse start S = 0 if b=0; S = SYMBOL_CYCLES/2 if b=1.
  - uwb_out=1 exactly when S ≤ counter < S+W, registered with no glitches.
  - At counter SYMBOL_CYCLES-1, both registers shift left by one (zero-fill) and the bit counter increments.
  - After DATA_W symbols, go to DONE.
- DONE: done=1 and busy=0 for one cycle, uwb_out=0, then IDLE.
- Frame length is DATA_W·SYMBOL_CYCLES cycles (1024 at defaults).
- send while busy or in DONE is ignored; no queueing.
- send held high continuously restarts a new frame the cycle after DONE.
- content/sk changes after capture have no effect.
- pw inputs are sampled only at symbol start, so mid-symbol changes apply from the next symbol.
- Reset mid-frame aborts immediately, with uwb_out=0 and no done strobe.

Optional Feature:
- Macro AUX_CHANNEL_EN.
- Defined: aux bit selects pw1/pw2 as above.
- Undefined: sk is not captured (aux register removed), the width always comes from pw1_bb0/pw1_bb1 per data bit, and pw2_* are ignored.
- Position modulation, timing and handshake are identical in both builds.

Decomposition:
- Package uwb_tx_pkg holds:
  - state enum {IDLE, TX, DONE};
  - default constants DATA_W, SYMBOL_CYCLES, PW_W;
  - a function computing clamped width from a code.
- One sub-module, uwb_pulse_gen:
  - contains the symbol counter, width latch and pulse shaping;
  - inputs: bit, aux, four width codes, symbol enable;
  - outputs: pulse, symbol_end.
- Top level holds the FSM, shift registers and bit counter.

Test Plan:
- Reset/idle: assert rst mid-frame at bit 40 → uwb_out=0, busy=0 immediately; no done; next send starts a fresh frame from content MSB.
- All-zero frame: content=0, sk=0, pw1_bb0=2'b00 → 128 single-cycle pulses, each at symbol cycle 0; busy for 1024 cycles, then done for 1 cycle.
- Position modulation: content=128'hAAAA…AA, sk=0, pw1_bb0=pw1_bb1=2'b00 → symbols alternate, pulse at cycle 4 (bit 1) then cycle 0 (bit 0), each 1 cycle wide.
- Aux width modulation (AUX_CHANNEL_EN): content=128'hAAAAAAAA, sk=128'h0000FFFF, pw1=2'b00, pw2=2'b10 → the lowest 16 symbols carry 3-cycle pulses, all others 1-cycle; without the macro, all pulses are 1 cycle.
- Clamp/boundary: pw1_bb1=2'b11 with SYMBOL_CYCLES=4 → width clamped to 2, pulse spans cycles 2–3 only.
- Handshake: pulse send again at cycle 100 of a frame → ignored, frame content unchanged; send held high → new frame begins the cycle after done.
